// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package mem_stage_sram_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLo   = 2'd1,
      StHi   = 2'd2,
      StDone = 2'd3
   } state_e;

   localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;
   localparam int unsigned SRAM_DW       = 16;
   localparam int unsigned SRAM_AW_DEF   = 18;
   localparam int unsigned CNT_W         = 4;

   // ready=0 freezes the pipeline registers and PC
   localparam logic READY_FREEZE = 1'b0;
   localparam logic READY_GO     = ~READY_FREEZE;

endpackage

// File: rtl/mem_stage_sram_ctrl_if.sv
// CPU-side request/response and SRAM control strobes of the MEM-stage controller.
interface mem_stage_sram_ctrl_if #(
   parameter int unsigned SRAM_AW = mem_stage_sram_ctrl_pkg::SRAM_AW_DEF
);
   logic               MEM_R_en;
   logic               MEM_W_en;
   logic [31:0]        address;
   logic [31:0]        write_data;
   logic [31:0]        read_data;
   logic               ready;
   logic [SRAM_AW-1:0] SRAM_ADDR;
   logic               SRAM_WE_N;
   logic               SRAM_OE_N;
   logic               SRAM_CE_N;
   logic               SRAM_UB_N;
   logic               SRAM_LB_N;

   modport master (
      output MEM_R_en, MEM_W_en, address, write_data,
      input  read_data, ready,
      input  SRAM_ADDR, SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N
   );

   modport slave (
      input  MEM_R_en, MEM_W_en, address, write_data,
      output read_data, ready,
      output SRAM_ADDR, SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N
   );
endinterface

// File: rtl/mem_stage_sram_ctrl_sram_dq_driver.sv
// Tri-state driver for the SRAM data bus plus the sampled input path.
module mem_stage_sram_ctrl_sram_dq_driver
   import mem_stage_sram_ctrl_pkg::*;
(
   input  logic               i_oe,
   input  logic [SRAM_DW-1:0] i_data,
   output logic [SRAM_DW-1:0] o_data,
   inout  wire  [SRAM_DW-1:0] io_dq
);
   assign io_dq  = i_oe ? i_data : {SRAM_DW{1'bz}};
   assign o_data = io_dq;
endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller: one 32-bit load/store as two 16-bit async-SRAM accesses,
// holding ready low until the second half completes.
module mem_stage_sram_ctrl
   import mem_stage_sram_ctrl_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR     = BASE_ADDR_DEF,
   parameter int unsigned ACCESS_CYCLES = 2,
   parameter int unsigned SRAM_AW       = SRAM_AW_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   mem_stage_sram_ctrl_if.slave bus,
   inout  wire  [SRAM_DW-1:0]   SRAM_DQ
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(ACCESS_CYCLES - 1);

   state_e             r_state, w_state_d;
   logic [CNT_W-1:0]   r_cnt, w_cnt_d;
   logic               r_wr, w_wr_d;
   logic [SRAM_DW-1:0] r_lo, r_hi, r_rd_lo;

   logic               w_last, w_half, w_dq_oe, w_ready;
   logic               w_ce_n, w_oe_n, w_we_n, w_byte_n;
   logic               w_smp_lo, w_smp_hi;
   logic [31:0]        w_off;
   logic [SRAM_DW-1:0] w_dq_out, w_dq_in;
   logic               w_unused;

   assign w_last = (r_cnt == LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_wr    <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_wr    <= w_wr_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_wr_d    = r_wr;
      w_ready   = READY_FREEZE;
      w_ce_n    = 1'b1;
      w_oe_n    = 1'b1;
      w_we_n    = 1'b1;
      w_byte_n  = 1'b1;
      w_dq_oe   = 1'b0;
      w_half    = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (bus.MEM_R_en || bus.MEM_W_en) begin
               w_state_d = StLo;
               w_cnt_d   = '0;
               w_wr_d    = bus.MEM_W_en; // store wins when both are set
            end else begin
               w_ready = READY_GO;
            end
         end
         StLo, StHi: begin
            w_half   = (r_state == StHi);
            w_ce_n   = 1'b0;
            w_byte_n = 1'b0;
            if (r_wr) begin
               // Last cycle keeps data driven with WE_N high for hold time
               w_dq_oe = 1'b1;
               w_we_n  = w_last;
            end else begin
               w_oe_n = 1'b0;
            end
            if (w_last) begin
               w_state_d = (r_state == StLo) ? StHi : StDone;
               w_cnt_d   = '0;
            end else begin
               w_cnt_d = r_cnt + 1'b1;
            end
         end
         StDone: begin
            w_ready   = READY_GO;
            w_state_d = StIdle;
         end
         default: w_state_d = StIdle;
      endcase
   end

   assign w_off    = bus.address - BASE_ADDR;
   assign w_dq_out = w_half ? bus.write_data[31:16] : bus.write_data[15:0];
   assign w_smp_lo = (r_state == StLo) && !r_wr && w_last;
   assign w_smp_hi = (r_state == StHi) && !r_wr && w_last;
   assign w_unused = ^{w_off[31:SRAM_AW+1], w_off[1:0]};

   mem_stage_sram_ctrl_sram_dq_driver u_dq (
      .i_oe   (w_dq_oe),
      .i_data (w_dq_out),
      .o_data (w_dq_in),
      .io_dq  (SRAM_DQ)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_lo <= '0;
      end else if (w_smp_lo) begin
         r_lo <= w_dq_in;
      end
   end

   // High latch doubles as read_data[31:16]; both halves land on the edge into DONE
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hi    <= '0;
         r_rd_lo <= '0;
      end else if (w_smp_hi) begin
         r_hi    <= w_dq_in;
         r_rd_lo <= r_lo;
      end
   end

   assign bus.read_data = {r_hi, r_rd_lo};
   assign bus.ready     = w_ready;
   assign bus.SRAM_ADDR = {w_off[SRAM_AW:2], w_half};
   assign bus.SRAM_CE_N = w_ce_n;
   assign bus.SRAM_OE_N = w_oe_n;
   assign bus.SRAM_WE_N = w_we_n;
   assign bus.SRAM_UB_N = w_byte_n;
   assign bus.SRAM_LB_N = w_byte_n;

endmodule
